// File: rtl/score_controller.sv
// score_controller: game-flow sequencer for two BCD scores, serve delay, winner detection and game-over blink
// Ports: clk/rst_n (async active-low); frame_tick, start_btn, goal1, goal2 in;
//  score1/score2 (4b), ball_hold, serve_pulse, serve_dir, score_vis, game_over, winner out (all registered).
module score_controller #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       goal1,
  input  logic       goal2,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       ball_hold,
  output logic       serve_pulse,
  output logic       serve_dir,
  output logic       score_vis,
  output logic       game_over,
  output logic       winner
);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, GAME_OVER} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score1_q, score1_d, score2_q, score2_d;
  logic       ball_hold_q, ball_hold_d, serve_pulse_q, serve_pulse_d, serve_dir_q, serve_dir_d;
  logic       score_vis_q, score_vis_d, game_over_q, game_over_d, winner_q, winner_d;
  logic       start_prev_q, start_edge;
  logic [3:0] s1_inc, s2_inc;
  assign start_edge = start_btn & ~start_prev_q;
  assign s1_inc     = score1_q + 4'd1;
  assign s2_inc     = score2_q + 4'd1;
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    score1_d      = score1_q;
    score2_d      = score2_q;
    serve_dir_d   = serve_dir_q;
    score_vis_d   = score_vis_q;
    winner_d      = winner_q;
    serve_pulse_d = 1'b0;
    case (state_q)
      IDLE: if (start_edge) begin
        score1_d    = 4'd0;
        score2_d    = 4'd0;
        serve_dir_d = 1'b0;
        cnt_d       = 8'd0;
        state_d     = SERVE;
      end
      SERVE: if (frame_tick) begin
        if (cnt_q == 8'(SERVE_FRAMES - 1)) begin
          serve_pulse_d = 1'b1;
          cnt_d         = 8'd0;
          state_d       = PLAY;
        end else cnt_d = cnt_q + 8'd1;
      end
      PLAY: if (goal1 | goal2) begin
        // simultaneous goals fall through as a replayed point
        cnt_d   = 8'd0;
        state_d = SERVE;
        if (goal1 & ~goal2) begin
          score1_d    = s1_inc;
          serve_dir_d = 1'b1;
          if (s1_inc == 4'(WIN_SCORE)) begin
            state_d  = GAME_OVER;
            winner_d = 1'b0;
          end
        end else if (goal2 & ~goal1) begin
          score2_d    = s2_inc;
          serve_dir_d = 1'b0;
          if (s2_inc == 4'(WIN_SCORE)) begin
            state_d  = GAME_OVER;
            winner_d = 1'b1;
          end
        end
      end
      GAME_OVER: if (start_edge) begin
        score1_d    = 4'd0;
        score2_d    = 4'd0;
        score_vis_d = 1'b1;
        serve_dir_d = ~winner_q;
        cnt_d       = 8'd0;
        state_d     = SERVE;
      end else if (frame_tick) begin
        if (cnt_q == 8'(BLINK_FRAMES - 1)) begin
          score_vis_d = ~score_vis_q;
          cnt_d       = 8'd0;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    ball_hold_d = state_d != PLAY;
    game_over_d = state_d == GAME_OVER;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      score1_q      <= 4'd0;
      score2_q      <= 4'd0;
      ball_hold_q   <= 1'b1;
      serve_pulse_q <= 1'b0;
      serve_dir_q   <= 1'b0;
      score_vis_q   <= 1'b1;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      start_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      ball_hold_q   <= ball_hold_d;
      serve_pulse_q <= serve_pulse_d;
      serve_dir_q   <= serve_dir_d;
      score_vis_q   <= score_vis_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      start_prev_q  <= start_btn;
    end
  end
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign ball_hold   = ball_hold_q;
  assign serve_pulse = serve_pulse_q;
  assign serve_dir   = serve_dir_q;
  assign score_vis   = score_vis_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
endmodule
